regfile_2r1w: RTL and testbench



---
 rtl/regfile_2r1w_pkg.sv | 8 +
 rtl/regfile_2r1w_regi_en.sv | 25 ++
 rtl/regfile_2r1w.sv | 52 +++++
 tb/tb_regfile_2r1w.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/regfile_2r1w_pkg.sv
// Shared sizing and option defaults for the register file and its datapath neighbours.
package regfile_2r1w_pkg;
  localparam int unsigned RF_WIDTH   = 32;
  localparam int unsigned RF_NREGS   = 32;
  localparam int unsigned RF_AW      = $clog2(RF_NREGS);
  localparam int unsigned RF_ZERO_R0 = 1;
  localparam int unsigned RF_BYPASS  = 1;
endpackage

// File: rtl/regfile_2r1w_regi_en.sv
// WIDTH-bit register with synchronous active-high reset and load enable.
module regi_en #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             r,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk) begin
    if (r) q_q <= '0;
    else   q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with optional hardwired-zero r0 and write-to-read bypass.
module regfile_2r1w
  import regfile_2r1w_pkg::*;
#(
  parameter int unsigned WIDTH   = RF_WIDTH,
  parameter int unsigned NREGS   = RF_NREGS,
  parameter int unsigned AW      = RF_AW,
  parameter int unsigned ZERO_R0 = RF_ZERO_R0,
  parameter int unsigned BYPASS  = RF_BYPASS
) (
  input  logic             clk,
  input  logic             r,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);
  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_ok;

  // Reset wins over a simultaneous write, so the decoder is gated by r as well.
  assign wr_ok = we && !r;

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if ((ZERO_R0 != 0) && (g == 0)) begin : g_zero
      assign regs[g] = '0;
    end else begin : g_store
      logic load;
      assign load = wr_ok && (wa == AW'(g));
      regi_en #(.WIDTH(WIDTH)) u_reg (
        .clk (clk),
        .r   (r),
        .en  (load),
        .d   (wd),
        .q   (regs[g])
      );
    end
  end

  // Bypass never applies to a hardwired-zero r0, so rd of address 0 stays 0.
  always_comb begin
    rd1 = regs[ra1];
    rd2 = regs[ra2];
    if ((BYPASS != 0) && wr_ok) begin
      if ((wa == ra1) && !((ZERO_R0 != 0) && (ra1 == '0))) rd1 = wd;
      if ((wa == ra2) && !((ZERO_R0 != 0) && (ra2 == '0))) rd2 = wd;
    end
  end
endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed and model-checked bench for regfile_2r1w: default build plus an 8x16, no-zero, no-bypass build.
module tb_regfile_2r1w;
  logic        clk = 1'b0;
  logic        r, we;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd, rd1, rd2;
  logic        r2, we2;
  logic [2:0]  wa2, ra1b, ra2b;
  logic [15:0] wd2, rd1b, rd2b;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] m  [32];
  logic [15:0] m2 [8];
  logic [31:0] e1, e2;

  always #5 clk = ~clk;

  regfile_2r1w u_dut (
    .clk(clk), .r(r), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
  );

  regfile_2r1w #(
    .WIDTH(16), .NREGS(8), .AW(3), .ZERO_R0(0), .BYPASS(0)
  ) u_alt (
    .clk(clk), .r(r2), .we(we2), .wa(wa2), .wd(wd2),
    .ra1(ra1b), .ra2(ra2b), .rd1(rd1b), .rd2(rd2b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    r = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    r2 = 1'b0; we2 = 1'b0; wa2 = '0; wd2 = '0; ra1b = '0; ra2b = '0;
    tick();

    // 1: reset, then every address reads zero on both ports
    r = 1'b1; r2 = 1'b1;
    tick();
    r = 1'b0; r2 = 1'b0;
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a); ra2 = 5'(31 - a);
      ra1b = 3'(a); ra2b = 3'(7 - (a % 8));
      #1;
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd2", rd2, 32'h0);
      if (a < 8) begin
        check("rst_alt_rd1", 32'(rd1b), 32'h0);
        check("rst_alt_rd2", 32'(rd2b), 32'h0);
      end
    end

    // 2: write then read next cycle on both ports
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd5; ra2 = 5'd5;
    #1;
    check("wr5_rd1", rd1, 32'hDEADBEEF);
    check("wr5_rd2", rd2, 32'hDEADBEEF);

    // 3: r0 hardwired to zero, including bypass
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd5;
    #1;
    check("r0_same", rd1, 32'h0);
    check("r0_other", rd2, 32'hDEADBEEF);
    tick();
    we = 1'b0;
    #1;
    check("r0_next", rd1, 32'h0);

    // r0 is ordinary in the alt build
    we2 = 1'b1; wa2 = 3'd0; wd2 = 16'hBEEF;
    tick();
    we2 = 1'b0; ra1b = 3'd0;
    #1;
    check("alt_r0", 32'(rd1b), 32'h0000BEEF);

    // 4: bypass vs no bypass
    we = 1'b1; wa = 5'd7; wd = 32'h1;
    we2 = 1'b1; wa2 = 3'd7; wd2 = 16'h1;
    tick();
    wd = 32'h2; ra1 = 5'd7; ra2 = 5'd7;
    wd2 = 16'h2; ra1b = 3'd7; ra2b = 3'd7;
    #1;
    check("byp_rd1", rd1, 32'h2);
    check("byp_rd2", rd2, 32'h2);
    check("nobyp_rd1", 32'(rd1b), 32'h1);
    check("nobyp_rd2", 32'(rd2b), 32'h1);
    tick();
    we = 1'b0; we2 = 1'b0;
    #1;
    check("byp_next", rd1, 32'h2);
    check("nobyp_next", 32'(rd1b), 32'h2);

    // 5: reset beats a simultaneous write; bypass suppressed during reset
    we = 1'b1; wa = 5'd3; wd = 32'h1234;
    tick();
    r = 1'b1; wd = 32'hABCD; ra1 = 5'd3; ra2 = 5'd5;
    #1;
    check("rst_nobyp", rd1, 32'h1234);
    tick();
    r = 1'b0; we = 1'b0;
    #1;
    check("rst_wr3", rd1, 32'h0);
    check("rst_clr5", rd2, 32'h0);

    // 6: random traffic against array models on both builds
    r = 1'b1; r2 = 1'b1; we = 1'b0; we2 = 1'b0;
    tick();
    r = 1'b0; r2 = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = '0;
    for (int i = 0; i < 8; i++) m2[i] = '0;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      we  = 1'($urandom_range(0, 1));
      wa  = 5'($urandom);
      wd  = $urandom;
      ra1 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom);
      r2   = ($urandom_range(0, 39) == 0);
      we2  = 1'($urandom_range(0, 1));
      wa2  = 3'($urandom);
      wd2  = 16'($urandom);
      ra1b = ($urandom_range(0, 2) == 0) ? wa2 : 3'($urandom);
      ra2b = ($urandom_range(0, 2) == 0) ? wa2 : 3'($urandom);
      #1;
      e1 = (we && !r && wa == ra1 && ra1 != 5'd0) ? wd : m[ra1];
      e2 = (we && !r && wa == ra2 && ra2 != 5'd0) ? wd : m[ra2];
      check("rnd_rd1", rd1, e1);
      check("rnd_rd2", rd2, e2);
      check("rnd_alt_rd1", 32'(rd1b), 32'(m2[ra1b]));
      check("rnd_alt_rd2", 32'(rd2b), 32'(m2[ra2b]));
      @(posedge clk);
      if (r) for (int k = 0; k < 32; k++) m[k] = '0;
      else if (we && wa != 5'd0) m[wa] = wd;
      if (r2) for (int k = 0; k < 8; k++) m2[k] = '0;
      else if (we2) m2[wa2] = wd2;
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
